// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and widths for the IF/MEM SRAM arbiter
package sram_arbiter_pkg;

   localparam int   SRAM_ADDR_W = 18;
   localparam int   SRAM_DATA_W = 16;
   localparam logic RST_ENABLE  = 1'b0;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ACCESS  = 2'd1,
      ARB_RECOVER = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } owner_t;

   // MEM wins when it is the only requester, or on a collision when preferred.
   function automatic logic pick_mem(input logic if_req, input logic mem_req,
                                     input logic prefer_mem);
      return mem_req & (~if_req | prefer_mem);
   endfunction

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - IF/MEM SRAM arbiter with multi-cycle strobe timing
// Optional SRAM_ARB_RR_EN: round-robin on collisions instead of fixed MEM priority.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = SRAM_DATA_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              stall_req,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t state, state_nxt;
   owner_t     owner;
   logic       we;
   logic [3:0] cnt;
   logic       grant, grant_mem, prefer_mem;

`ifdef SRAM_ARB_RR_EN
   owner_t last_owner;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         last_owner <= OWNER_IF;
      else if (grant)
         last_owner <= grant_mem ? OWNER_MEM : OWNER_IF;
   end

   assign prefer_mem = (last_owner == OWNER_IF);
`else
   assign prefer_mem = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_mem = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (mem_req | if_req) begin
               grant     = 1'b1;
               grant_mem = pick_mem(if_req, mem_req, prefer_mem);
               state_nxt = ARB_ACCESS;
            end
         end
         ARB_ACCESS:  if (cnt == 4'd0) state_nxt = ARB_RECOVER;
         ARB_RECOVER: state_nxt = ARB_IDLE;
         default:     state_nxt = ARB_IDLE;
      endcase
   end

   // Request inputs are copied at grant so mid-access changes cannot disturb the cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         owner     <= OWNER_IF;
         we        <= 1'b0;
         cnt       <= 4'd0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         if (grant) begin
            owner    <= grant_mem ? OWNER_MEM : OWNER_IF;
            we       <= grant_mem & mem_we;
            cnt      <= 4'(WAIT_CYCLES - 1);
            ram_addr <= grant_mem ? mem_addr : if_addr;
            if (grant_mem)
               ram_wdata <= mem_wdata;
         end else if (state == ARB_ACCESS) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd0 && !we) begin
               if (owner == OWNER_MEM)
                  mem_rdata <= ram_rdata;
               else
                  if_rdata <= ram_rdata;
            end
         end
      end
   end

   // Chip enable spans ACCESS and RECOVER; bus drive also spans both for write hold time.
   assign ram_ce_n    = (state == ARB_IDLE);
   assign ram_oe_n    = !((state == ARB_ACCESS) && !we);
   assign ram_we_n    = !((state == ARB_ACCESS) && we);
   assign ram_data_oe = we && (state != ARB_IDLE);

   assign if_ack  = (state == ARB_RECOVER) && (owner == OWNER_IF);
   assign mem_ack = (state == ARB_RECOVER) && (owner == OWNER_MEM);

   assign stall_req = (rst != RST_ENABLE) &&
                      ((if_req & ~if_ack) | (mem_req & ~mem_ack));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter (either SRAM_ARB_RR_EN build)
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we;
   logic [17:0] if_addr, mem_addr, ram_addr;
   logic [15:0] mem_wdata, if_rdata, mem_rdata, ram_wdata, ram_rdata;
   logic        if_ack, mem_ack, stall_req;
   logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;

   logic [15:0] sram_model [0:1023];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_if, exp_mem;

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
      .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_data_oe(ram_data_oe),
      .ram_rdata(ram_rdata)
   );

   always @(posedge clk)
      if (!ram_ce_n && !ram_we_n)
         sram_model[ram_addr[9:0]] <= ram_wdata;

   assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? sram_model[ram_addr[9:0]] : 16'hDEAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_access(input vec_t v);
      int   n;
      logic got;
      if (v.is_mem) begin
         mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (n <= 2) begin
            check("strobe_active", v.we ? ram_we_n : ram_oe_n, 0);
            check("stall_busy", stall_req, 1);
         end
         if (v.is_mem ? mem_ack : if_ack) got = 1'b1;
      end
      check("ack_latency", n, 3);
      check("strobes_recover", {ram_oe_n, ram_we_n, ram_ce_n}, 3'b110);
      check("data_oe_hold", ram_data_oe, v.we);
      check("stall_at_ack", stall_req, 0);
      check("other_ack", v.is_mem ? if_ack : mem_ack, 0);
      mem_req = 1'b0;
      if_req  = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", {if_ack, mem_ack}, 2'b00);
      if (!v.we) begin
         if (v.is_mem) exp_mem = v.exp_rd;
         else          exp_if  = v.exp_rd;
      end
      check("if_rdata", if_rdata, exp_if);
      check("mem_rdata", mem_rdata, exp_mem);
      if (v.we) check("model_write", sram_model[v.addr[9:0]], v.wdata);
   endtask

   initial begin
      int if_at, mem_at, if_cnt, mem_cnt, stall_low, ce_cnt;
      vec_t v;

      vecs[0] = '{1'b1, 1'b1, 18'h00010, 16'h1234, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 16'h1234};
      vecs[2] = '{1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 16'hBEEF};
      vecs[4] = '{1'b1, 1'b1, 18'h00020, 16'h0F0F, 16'h0000};
      vecs[5] = '{1'b0, 1'b0, 18'h00020, 16'h0000, 16'h0F0F};
      vecs[6] = '{1'b1, 1'b0, 18'h00010, 16'h0000, 16'h1234};

      rst = 1'b0;
      if_req = 1'b1; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      exp_if = '0; exp_mem = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_rdata", {if_rdata, mem_rdata}, 0);
      check("rst_acks", {if_ack, mem_ack}, 0);
      check("rst_stall", stall_req, 0);
      if_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) do_access(vecs[i]);

      // Collision: default MEM first; round-robin serves IF since the last grant was MEM.
      if_req = 1'b1; if_addr = 18'h00010;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h3FFFF;
      if_at = 0; mem_at = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (n == 3) check("collide_stall", stall_req, 1);
         if (mem_ack) begin mem_at = n; mem_req = 1'b0; end
         if (if_ack)  begin if_at = n;  if_req = 1'b0; end
      end
`ifdef SRAM_ARB_RR_EN
      check("collide_if_at", if_at, 3);
      check("collide_mem_at", mem_at, 7);
`else
      check("collide_mem_at", mem_at, 3);
      check("collide_if_at", if_at, 7);
`endif
      check("collide_if_rdata", if_rdata, 16'h1234);
      check("collide_mem_rdata", mem_rdata, 16'hBEEF);
      exp_if = 16'h1234; exp_mem = 16'hBEEF;

      // Back-to-back MEM traffic with IF waiting.
      if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
      if_cnt = 0; mem_cnt = 0; stall_low = 0;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
         if (if_ack)  if_cnt++;
         if (mem_ack) mem_cnt++;
         if (!stall_req) stall_low++;
      end
      if_req = 1'b0; mem_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
      check("starve_if_acks", if_cnt, 2);
      check("starve_mem_acks", mem_cnt, 2);
`else
      check("starve_if_acks", if_cnt, 0);
      check("starve_mem_acks", mem_cnt, 4);
`endif
      check("starve_stall_held", stall_low, 0);
      repeat (4) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a write.
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00030; mem_wdata = 16'h7777;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_we", ram_we_n, 0);
      rst = 1'b0;
      #1;
      check("async_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
      check("async_addr", ram_addr, 0);
      check("async_stall", stall_req, 0);
      check("async_rdata", {if_rdata, mem_rdata}, 0);
      mem_req = 1'b0; mem_we = 1'b0;
      exp_if = '0; exp_mem = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      v = '{1'b0, 1'b0, 18'h00010, 16'h0000, 16'h1234};
      do_access(v);

      // IF request dropped right after the grant.
      if_req = 1'b1; if_addr = 18'h00020;
      if_cnt = 0; ce_cnt = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (n == 1) if_req = 1'b0;
         if (if_ack) if_cnt++;
         if (!ram_ce_n) ce_cnt++;
      end
      check("drop_ack_once", if_cnt, 1);
      check("drop_no_reaccess", ce_cnt, 3);
      check("drop_if_rdata", if_rdata, 16'h0F0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM between the instruction-fetch (IF) port and the data-access (MEM) port of the THCO-MIPS pipeline.
- Sequences multi-cycle SRAM read/write timing: chip enable, output enable, write enable and the tristate data enable.
- Raises a stall request to the pipeline controller while any port's request is outstanding.
- Sits between the pipeline stages and the board SRAM pins, instantiated in top.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, cycles the strobe is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (`RstEnable` = 1'b0).
- if_req  in  1  IF read request; level, held until if_ack.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  IF read data.
- if_ack  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request; level, held until mem_ack.
- mem_we  in  1  MEM write (1) or read (0).
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- stall_req  out  1  pipeline stall request.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low.
- ram_addr  out  ADDR_W  SRAM address.
- ram_wdata  out  DATA_W  data driven onto the SRAM bus.
- ram_data_oe  out  1  tristate enable for the SRAM bus; the bus itself is driven in top.
- ram_rdata  in  DATA_W  data sampled from the SRAM bus.

Behaviour:

FSM states:
- IDLE: samples requests.
  - Grants MEM when mem_req=1; otherwise grants IF when if_req=1; stays in IDLE when neither is high.
  - On grant: registers owner, address, we and wdata; loads cnt = WAIT_CYCLES-1; moves to ACCESS.
- ACCESS:
  - ram_ce_n=0.
  - Read: ram_oe_n=0, ram_we_n=1.
  - Write: ram_we_n=0, ram_oe_n=1, ram_data_oe=1.
  - cnt decrements each cycle. When cnt==0, read data is captured from ram_rdata into the owner's rdata register and the FSM moves to RECOVER.
- RECOVER:
  - ram_we_n=1 and ram_oe_n=1; ram_ce_n stays 0.
  - ram_data_oe stays 1 for a write (hold time); address is held.
  - Owner's ack=1 for exactly this cycle; next state IDLE.

Latency and throughput:
- Request seen in IDLE at cycle T: strobes active T+1..T+WAIT_CYCLES, ack at T+WAIT_CYCLES+1, earliest next grant at T+WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles.

Read data and acks:
- if_rdata and mem_rdata are updated only by their own reads and hold their value otherwise.
- mem_rdata is unchanged by writes.
- The non-owner ack is always 0.

Stall:
- stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack); combinational.

Boundary conditions:
- Simultaneous requests in IDLE: MEM wins; IF waits and is granted on the next IDLE.
- Request dropped mid-access: the access still completes and ack still pulses.
- Request changes mid-access: ignored, because the registered copy is used.
- Reset asserted at any time forces immediately:
  - state=IDLE
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_data_oe=0
  - ram_addr=0, ram_wdata=0
  - if_rdata=mem_rdata=0, acks=0
  - stall_req=0 while reset is low.

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - A last_owner flag (reset to IF) is updated at each grant.
  - On simultaneous requests in IDLE, the port that did not own the previous grant wins.
  - Prevents IF starvation under back-to-back MEM traffic.
- SRAM_ARB_RR_EN undefined: fixed MEM-over-IF priority, and no last_owner register exists.

Decomposition:
- defines.v holds:
  - state encodings `ArbIdle`/`ArbAccess`/`ArbRecover` (2 bits)
  - owner encodings `OwnerIf`/`OwnerMem`
  - existing `RstEnable`/`RstDisable`
  - `SramAddrBus`/`SramDataBus` width macros
- No sub-module: the counter and FSM are small enough for one module.

Test Plan (WAIT_CYCLES=2):
- IF read, addr 0x00010, SRAM model returns 0x1234 → ram_oe_n low for 2 cycles, if_ack pulses 3 cycles after the request is seen, if_rdata=0x1234, stall_req drops the same cycle.
- MEM write, addr 0x3FFFF, data 0xBEEF → ram_we_n low 2 cycles then high with ram_data_oe still 1 for one cycle; model holds 0xBEEF; mem_rdata unchanged.
- if_req and mem_req rise together → MEM served first (mem_ack at +3), IF ack at +7; with SRAM_ARB_RR_EN, a repeated collision after a MEM grant serves IF first.
- mem_req held continuously for 4 accesses while if_req=1 → without RR, IF is never acked and stall_req stays 1; with RR, grants alternate MEM/IF.
- rst low during ACCESS of a write → all strobes high and ram_data_oe=0 in the same cycle (asynchronous); after release, state IDLE and the next request is served normally.
- if_req deasserted after the grant → if_ack still pulses once; no second access starts.
